// File: rtl/seg7_reader_if.sv
// seg7_reader_if: stream bundle for the 7-segment reader.
//   Input side : in_valid/in_ready handshake, in_first (digit 0 marker), in_segs (active-low a..g).
//   Output side: out_valid/out_ready handshake, out_data (DIGITS nibbles), out_err (per digit),
//                resync (sticky restart indicator).
// Modports: slave = the reader block, master = the producer/consumer around it.
interface seg7_reader_if #(
  parameter int unsigned DIGITS = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_first;
  logic [6:0]            in_segs;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_data;
  logic [DIGITS-1:0]     out_err;
  logic                  resync;

  modport slave (
    input  in_valid, in_first, in_segs, out_ready,
    output in_ready, out_valid, out_data, out_err, resync
  );

  modport master (
    output in_valid, in_first, in_segs, out_ready,
    input  in_ready, out_valid, out_data, out_err, resync
  );
endinterface

// File: rtl/seg7_reader.sv
// seg7_reader: decodes a stream of active-low 7-segment patterns back into nibbles and
// assembles DIGITS of them into one frame word, handed downstream via valid/ready.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - seg7_reader_if.slave (segment input stream, frame output stream, resync flag)
// Optional build macro SEG7_READER_STABLE_EN: a frame is presented only when it equals the
// previously completed frame (glitch filter for scanned display buses).
module seg7_reader #(
  parameter int unsigned DIGITS = 6
) (
  input logic           clk,
  input logic           reset_n,
  seg7_reader_if.slave  bus
);

  localparam int unsigned CntW    = 3;
  localparam logic [CntW-1:0] LastIdx = CntW'(DIGITS - 1);

  typedef enum logic [1:0] {StSync, StCollect, StHold} state_e;

  state_e                r_state;
  logic [CntW-1:0]       r_cnt;
  logic [4*DIGITS-1:0]   r_stage_data;
  logic [DIGITS-1:0]     r_stage_err;
  logic [4*DIGITS-1:0]   r_out_data;
  logic [DIGITS-1:0]     r_out_err;
  logic                  r_out_valid;
  logic                  r_resync;
  logic                  r_restart;    // current/held frame was restarted mid-collection
`ifdef SEG7_READER_STABLE_EN
  logic [4*DIGITS-1:0]   r_ref_data;
  logic [DIGITS-1:0]     r_ref_err;
`endif

  logic [3:0]            w_nib;
  logic                  w_bad;
  logic [CntW-1:0]       w_idx;
  logic                  w_last;
  logic                  w_in_ready;
  logic                  w_accept;
  logic [4*DIGITS-1:0]   w_data;
  logic [DIGITS-1:0]     w_err;

  assign w_in_ready = (r_state != StHold);

  always_comb begin
    w_nib = 4'h0;
    w_bad = 1'b0;
    case (bus.in_segs)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h18: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: begin
        w_nib = 4'h0;
        w_bad = 1'b1;
      end
    endcase
  end

  // Frame as it would look with the current digit merged in; in_first starts a clean frame.
  always_comb begin
    w_idx  = bus.in_first ? '0 : r_cnt;
    w_last = (w_idx == LastIdx);
    w_data = bus.in_first ? '0 : r_stage_data;
    w_err  = bus.in_first ? '0 : r_stage_err;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (w_idx == CntW'(k)) begin
        w_data[4*k +: 4] = w_nib;
        w_err[k]         = w_bad;
      end
    end
  end

  // Transfers without in_first while in SYNC are consumed but ignored.
  assign w_accept = bus.in_valid & w_in_ready & (bus.in_first | (r_state == StCollect));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StSync;
      r_cnt        <= '0;
      r_stage_data <= '0;
      r_stage_err  <= '0;
      r_out_data   <= '0;
      r_out_err    <= '0;
      r_out_valid  <= 1'b0;
      r_resync     <= 1'b0;
      r_restart    <= 1'b0;
`ifdef SEG7_READER_STABLE_EN
      r_ref_data   <= '1;
      r_ref_err    <= '1;
`endif
    end else if (w_accept) begin
      if (bus.in_first) begin
        r_restart <= (r_state == StCollect);
        if (r_state == StCollect) r_resync <= 1'b1;
      end
      if (w_last) begin
        r_cnt <= '0;
`ifdef SEG7_READER_STABLE_EN
        r_ref_data <= w_data;
        r_ref_err  <= w_err;
        if ((w_data == r_ref_data) && (w_err == r_ref_err)) begin
          r_out_data  <= w_data;
          r_out_err   <= w_err;
          r_out_valid <= 1'b1;
          r_state     <= StHold;
        end else begin
          r_state <= StSync;
        end
`else
        r_out_data  <= w_data;
        r_out_err   <= w_err;
        r_out_valid <= 1'b1;
        r_state     <= StHold;
`endif
      end else begin
        r_stage_data <= w_data;
        r_stage_err  <= w_err;
        r_cnt        <= w_idx + CntW'(1);
        r_state      <= StCollect;
      end
    end else if ((r_state == StHold) && bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_state     <= StSync;
      if (!r_restart) r_resync <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;
  assign bus.resync    = r_resync;

endmodule

// File: tb/tb_seg7_reader.sv
module tb_seg7_reader;
  localparam int unsigned DIGITS = 6;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  seg7_reader_if #(.DIGITS(DIGITS)) bus_if ();

  seg7_reader #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one beat, let the edge happen, return 1 time unit after it.
  task automatic xfer(input logic [6:0] segs, input logic first);
    bus_if.in_valid = 1'b1;
    bus_if.in_segs  = segs;
    bus_if.in_first = first;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.in_valid = 1'b0;
    bus_if.in_first = 1'b0;
  endtask

  // pats: digit k pattern at [7k+6:7k]; in_first on digit 0 only.
  task automatic send_frame(input logic [41:0] pats);
    for (int k = 0; k < 6; k++) xfer(pats[7*k +: 7], (k == 0));
    idle();
  endtask

  task automatic handoff(input string tag);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    check_eq({tag, "_valid_fall"}, {31'd0, bus_if.out_valid}, 32'd0);
  endtask

  // Frame patterns, digit 0 in the low bits.
  localparam logic [41:0] FrmA   = {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}; // 543210
  localparam logic [41:0] FrmBad = {7'h12, 7'h19, 7'h30, 7'h7F, 7'h79, 7'h40}; // 543010 err 2
  localparam logic [41:0] FrmF   = {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}; // ABCDEF

  int n_pres;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_pres = 0;
    reset_n = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_first  = 1'b0;
    bus_if.in_segs   = 7'h7F;
    bus_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("rst_data", {8'd0, bus_if.out_data}, 32'd0);
    check_eq("rst_err", {26'd0, bus_if.out_err}, 32'd0);
    check_eq("rst_resync", {31'd0, bus_if.resync}, 32'd0);
    check_eq("rst_ready", {31'd0, bus_if.in_ready}, 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef SEG7_READER_STABLE_EN
    // A, A, B, B: only the second of each pair is presented.
    send_frame(FrmA);
    check_eq("st_a1_valid", {31'd0, bus_if.out_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq("st_a1_valid2", {31'd0, bus_if.out_valid}, 32'd0);
    send_frame(FrmA);
    check_eq("st_a2_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check_eq("st_a2_data", {8'd0, bus_if.out_data}, 32'h543210);
    if (bus_if.out_valid) n_pres++;
    handoff("st_a2");
    @(posedge clk); #1;
    send_frame(FrmF);
    check_eq("st_b1_valid", {31'd0, bus_if.out_valid}, 32'd0);
    @(posedge clk); #1;
    send_frame(FrmF);
    check_eq("st_b2_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check_eq("st_b2_data", {8'd0, bus_if.out_data}, 32'hABCDEF);
    if (bus_if.out_valid) n_pres++;
    handoff("st_b2");
    check_eq("st_presentations", n_pres, 32'd2);
`else
    // Basic frame; nothing presented before the last digit.
    for (int k = 0; k < 5; k++) xfer(FrmA[7*k +: 7], (k == 0));
    check_eq("f1_early_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("f1_collect_ready", {31'd0, bus_if.in_ready}, 32'd1);
    xfer(FrmA[35 +: 7], 1'b0);
    idle();
    check_eq("f1_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check_eq("f1_data", {8'd0, bus_if.out_data}, 32'h543210);
    check_eq("f1_err", {26'd0, bus_if.out_err}, 32'h0);
    check_eq("f1_resync", {31'd0, bus_if.resync}, 32'd0);
    handoff("f1");
    @(posedge clk); #1;

    // Illegal pattern in digit 2, then a 10-cycle stall with input pressure.
    send_frame(FrmBad);
    check_eq("f2_data", {8'd0, bus_if.out_data}, 32'h543010);
    check_eq("f2_err", {26'd0, bus_if.out_err}, 32'h04);
    bus_if.in_valid = 1'b1;
    bus_if.in_first = 1'b1;
    bus_if.in_segs  = 7'h79;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_eq($sformatf("hold_ready_%0d", c), {31'd0, bus_if.in_ready}, 32'd0);
    end
    check_eq("hold_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check_eq("hold_data", {8'd0, bus_if.out_data}, 32'h543010);
    check_eq("hold_err", {26'd0, bus_if.out_err}, 32'h04);
    idle();
    handoff("f2");
    check_eq("f2_after_ready", {31'd0, bus_if.in_ready}, 32'd1);

    // Orphan digits without in_first are dropped.
    xfer(7'h18, 1'b0);
    xfer(7'h08, 1'b0);
    idle();
    @(posedge clk); #1;
    check_eq("orphan_valid", {31'd0, bus_if.out_valid}, 32'd0);
    send_frame(FrmF);
    check_eq("f3_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check_eq("f3_data", {8'd0, bus_if.out_data}, 32'hABCDEF);
    check_eq("f3_err", {26'd0, bus_if.out_err}, 32'h0);
    handoff("f3");
    @(posedge clk); #1;

    // Restart on 4th transfer; partial frame (with an illegal digit) is discarded.
    xfer(7'h40, 1'b1);
    xfer(7'h7F, 1'b0);
    xfer(7'h24, 1'b0);
    xfer(7'h02, 1'b1);
    check_eq("rs_flag_early", {31'd0, bus_if.resync}, 32'd1);
    xfer(7'h78, 1'b0);
    xfer(7'h00, 1'b0);
    xfer(7'h18, 1'b0);
    xfer(7'h08, 1'b0);
    check_eq("rs_early_valid", {31'd0, bus_if.out_valid}, 32'd0);
    xfer(7'h03, 1'b0);
    idle();
    check_eq("rs_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check_eq("rs_data", {8'd0, bus_if.out_data}, 32'hBA9876);
    check_eq("rs_err", {26'd0, bus_if.out_err}, 32'h0);
    check_eq("rs_resync", {31'd0, bus_if.resync}, 32'd1);
    handoff("rs");
    check_eq("rs_sticky", {31'd0, bus_if.resync}, 32'd1);
    @(posedge clk); #1;

    // Clean frame: resync holds until its handoff, then clears.
    send_frame(FrmA);
    check_eq("cl_resync_pre", {31'd0, bus_if.resync}, 32'd1);
    check_eq("cl_data", {8'd0, bus_if.out_data}, 32'h543210);
    handoff("cl");
    check_eq("cl_resync_post", {31'd0, bus_if.resync}, 32'd0);
    @(posedge clk); #1;

    // Identical frame again is presented as well.
    send_frame(FrmA);
    check_eq("rep_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check_eq("rep_data", {8'd0, bus_if.out_data}, 32'h543210);

    // Reset while holding drops the frame immediately.
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("mid_rst_data", {8'd0, bus_if.out_data}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, bus_if.in_ready}, 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
